bitonic_topk_accum: RTL and testbench



---
 rtl/bitonic_topk_accum.sv | 248 ++++++++++++++++++++++++
 tb/tb_bitonic_topk_accum.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitonic_topk_accum.sv
`default_nettype none
// ============================================================================
// Module   : bitonic_topk_accum
// Purpose  : Running top-K selector for kNN search. Each cycle accepts one
//            batch of N (distance, index) candidates from a single leaf and
//            sorts it with a fully registered ascending bitonic network. The
//            K best elements of each batch are merged into a running best-K
//            list. The final list for a query is emitted once, ascending,
//            when that query's last batch reaches the accumulator.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            valid_in        - batch valid (no backpressure)
//            query_first_in  - batch opens a new query
//            query_last_in   - batch closes the current query
//            leaf_idx_in     - leaf that all N candidates come from
//            data_in/idx_in  - packed distances / indices, element i at
//                              [i*W +: W]
//            valid_out       - one-cycle pulse, final list loaded
//            data_out/idx_out/leaf_out - final list, element 0 is smallest
// Options  : TOPK_DIST_THRESH_EN adds dist_thresh_in (candidates with
//            data >= threshold become sentinels) and elem_valid_out
//            (per-element "not a sentinel" flag).
// Revision : 1.0 - initial release
// ============================================================================
module bitonic_topk_accum #(
   parameter int DATA_W = 25,
   parameter int IDX_W  = 9,
   parameter int LEAF_W = 6,
   parameter int N      = 8,
   parameter int K      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_in,
   input  logic                  query_first_in,
   input  logic                  query_last_in,
   input  logic [LEAF_W-1:0]     leaf_idx_in,
   input  logic [N*DATA_W-1:0]   data_in,
   input  logic [N*IDX_W-1:0]    idx_in,
`ifdef TOPK_DIST_THRESH_EN
   input  logic [DATA_W-1:0]     dist_thresh_in,
   output logic [K-1:0]          elem_valid_out,
`endif
   output logic                  valid_out,
   output logic [K*DATA_W-1:0]   data_out,
   output logic [K*IDX_W-1:0]    idx_out,
   output logic [K*LEAF_W-1:0]   leaf_out
);

   // Sort key {data, leaf, idx}: comparing the whole vector as one unsigned
   // value breaks distance ties by leaf, then by index.
   localparam int KEY_W = DATA_W + LEAF_W + IDX_W;
   localparam int LOG2N = $clog2(N);
   localparam int LOG2K = $clog2(K);
   localparam int S     = LOG2N * (LOG2N + 1) / 2;
   localparam logic [KEY_W-1:0] SENTINEL = {{DATA_W{1'b1}}, {(LEAF_W + IDX_W){1'b0}}};

   // ---------------------------------------------------------------------
   // Input element formation
   // ---------------------------------------------------------------------
   logic [KEY_W-1:0] in_elem [N];

   for (genvar i = 0; i < N; i++) begin : g_in
      logic [DATA_W-1:0] d;
      assign d = data_in[i*DATA_W +: DATA_W];
`ifdef TOPK_DIST_THRESH_EN
      assign in_elem[i] = (d >= dist_thresh_in) ? SENTINEL
                                                : {d, leaf_idx_in, idx_in[i*IDX_W +: IDX_W]};
`else
      assign in_elem[i] = {d, leaf_idx_in, idx_in[i*IDX_W +: IDX_W]};
`endif
   end

   // ---------------------------------------------------------------------
   // Sideband pipeline: vld_d[s] is the valid entering stage s
   // ---------------------------------------------------------------------
   logic [S-1:0] vld_d, vld_q;
   logic [S-1:0] first_d, first_q;
   logic [S-1:0] last_d, last_q;

   always_comb begin
      vld_d   = '0;
      first_d = first_q;
      last_d  = last_q;
      vld_d[0] = valid_in;
      for (int s = 1; s < S; s++) begin
         vld_d[s] = vld_q[s-1];
      end
      if (valid_in) begin
         first_d[0] = query_first_in;
         last_d[0]  = query_last_in;
      end
      for (int s = 1; s < S; s++) begin
         if (vld_q[s-1]) begin
            first_d[s] = first_q[s-1];
            last_d[s]  = last_q[s-1];
         end
      end
   end

   // ---------------------------------------------------------------------
   // Bitonic sort network. Stages 0..S-2 carry all N elements; the last
   // stage (distance-1 compare within adjacent pairs) only needs to produce
   // the first K outputs.
   // ---------------------------------------------------------------------
   logic [KEY_W-1:0] stg_d [S-1][N];
   logic [KEY_W-1:0] stg_q [S-1][N];
   logic [KEY_W-1:0] fin_d [K];
   logic [KEY_W-1:0] fin_q [K];

   for (genvar p = 1; p <= LOG2N; p++) begin : g_phase
      for (genvar qq = 0; qq < p; qq++) begin : g_step
         localparam int SI  = p * (p - 1) / 2 + qq;
         localparam int J   = 1 << (p - 1 - qq);
         localparam int BLK = 1 << p;
         for (genvar i = 0; i < N; i++) begin : g_cx
            localparam int PP       = i ^ J;
            localparam bit ASC      = ((i & BLK) == 0);
            localparam bit TAKE_MIN = ((i < PP) == ASC);
            if (SI < S - 1 || i < K) begin : g_live
               logic [KEY_W-1:0] a, b, cx;
               if (SI == 0) begin : g_src_in
                  assign a = in_elem[i];
                  assign b = in_elem[PP];
               end else begin : g_src_stg
                  assign a = stg_q[SI-1][i];
                  assign b = stg_q[SI-1][PP];
               end
               if (TAKE_MIN) begin : g_min
                  assign cx = (b < a) ? b : a;
               end else begin : g_max
                  assign cx = (b < a) ? a : b;
               end
               // Stage registers hold when nothing valid is arriving
               if (SI < S - 1) begin : g_mid
                  assign stg_d[SI][i] = vld_d[SI] ? cx : stg_q[SI][i];
               end else begin : g_last
                  assign fin_d[i] = vld_d[SI] ? cx : fin_q[i];
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Accumulator and output registers
   // ---------------------------------------------------------------------
   logic [KEY_W-1:0] r_d    [K];
   logic [KEY_W-1:0] r_q    [K];
   logic [KEY_W-1:0] mrg    [K];
   logic [KEY_W-1:0] dout_d [K];
   logic [KEY_W-1:0] dout_q [K];
   logic [KEY_W-1:0] tmp;
   logic             valid_out_d, valid_out_q;
   logic             load;
`ifdef TOPK_DIST_THRESH_EN
   logic [K-1:0]     ev_d, ev_q;
`endif

   always_comb begin
      tmp = '0;
      // R ascending against B descending: elementwise min yields a bitonic
      // sequence holding exactly the K smallest of R and B.
      for (int i = 0; i < K; i++) begin
         mrg[i] = (fin_q[K-1-i] < r_q[i]) ? fin_q[K-1-i] : r_q[i];
      end
      // Half-cleaner cascade sorts that bitonic sequence ascending
      for (int p = LOG2K - 1; p >= 0; p--) begin
         for (int i = 0; i < K; i++) begin
            if ((i & (1 << p)) == 0) begin
               if (mrg[i + (1 << p)] < mrg[i]) begin
                  tmp                = mrg[i];
                  mrg[i]             = mrg[i + (1 << p)];
                  mrg[i + (1 << p)]  = tmp;
               end
            end
         end
      end

      // A first batch replaces the list, discarding any open query
      for (int i = 0; i < K; i++) begin
         r_d[i] = r_q[i];
         if (vld_q[S-1]) begin
            r_d[i] = first_q[S-1] ? fin_q[i] : mrg[i];
         end
      end

      load        = vld_q[S-1] & last_q[S-1];
      valid_out_d = load;
      for (int i = 0; i < K; i++) begin
         dout_d[i] = load ? r_d[i] : dout_q[i];
      end
`ifdef TOPK_DIST_THRESH_EN
      ev_d = ev_q;
      for (int i = 0; i < K; i++) begin
         if (load) begin
            ev_d[i] = (r_d[i][KEY_W-1 -: DATA_W] != {DATA_W{1'b1}});
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q       <= '0;
         first_q     <= '0;
         last_q      <= '0;
         valid_out_q <= 1'b0;
         for (int s = 0; s < S - 1; s++) begin
            for (int i = 0; i < N; i++) begin
               stg_q[s][i] <= '0;
            end
         end
         for (int i = 0; i < K; i++) begin
            fin_q[i]  <= '0;
            r_q[i]    <= SENTINEL;
            dout_q[i] <= '0;
         end
`ifdef TOPK_DIST_THRESH_EN
         ev_q <= '0;
`endif
      end else begin
         vld_q       <= vld_d;
         first_q     <= first_d;
         last_q      <= last_d;
         valid_out_q <= valid_out_d;
         stg_q       <= stg_d;
         fin_q       <= fin_d;
         r_q         <= r_d;
         dout_q      <= dout_d;
`ifdef TOPK_DIST_THRESH_EN
         ev_q <= ev_d;
`endif
      end
   end

   assign valid_out = valid_out_q;
`ifdef TOPK_DIST_THRESH_EN
   assign elem_valid_out = ev_q;
`endif

   for (genvar i = 0; i < K; i++) begin : g_out
      assign data_out[i*DATA_W +: DATA_W] = dout_q[i][KEY_W-1 -: DATA_W];
      assign leaf_out[i*LEAF_W +: LEAF_W] = dout_q[i][IDX_W +: LEAF_W];
      assign idx_out[i*IDX_W +: IDX_W]    = dout_q[i][IDX_W-1:0];
   end

endmodule
`default_nettype wire

// File: tb/tb_bitonic_topk_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_bitonic_topk_accum
// Purpose  : Self-checking bench for bitonic_topk_accum (N=8, K=4). A
//            reference model keeps the running best-K list as a plain sorted
//            pool; every closing batch pushes the expected list into a queue
//            that an independent monitor pops on each valid_out pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bitonic_topk_accum;

   localparam int DW = 25;
   localparam int IW = 9;
   localparam int LW = 6;
   localparam int N  = 8;
   localparam int K  = 4;
   localparam int KW = DW + LW + IW;

   typedef logic [KW-1:0]   key_t;
   typedef logic [K*KW-1:0] list_t;

   localparam key_t SENT = {{DW{1'b1}}, {(LW + IW){1'b0}}};

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            valid_in = 1'b0;
   logic            first_in = 1'b0;
   logic            last_in = 1'b0;
   logic [LW-1:0]   leaf_in = '0;
   logic [N*DW-1:0] data_in = '0;
   logic [N*IW-1:0] idx_in = '0;
   logic            valid_out;
   logic [K*DW-1:0] data_out;
   logic [K*IW-1:0] idx_out;
   logic [K*LW-1:0] leaf_out;
`ifdef TOPK_DIST_THRESH_EN
   logic [DW-1:0]   thr = '1;
   logic [K-1:0]    elem_valid_out;
`endif

   always #5 clk = ~clk;

   bitonic_topk_accum #(
      .DATA_W(DW), .IDX_W(IW), .LEAF_W(LW), .N(N), .K(K)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .valid_in       (valid_in),
      .query_first_in (first_in),
      .query_last_in  (last_in),
      .leaf_idx_in    (leaf_in),
      .data_in        (data_in),
      .idx_in         (idx_in),
`ifdef TOPK_DIST_THRESH_EN
      .dist_thresh_in (thr),
      .elem_valid_out (elem_valid_out),
`endif
      .valid_out      (valid_out),
      .data_out       (data_out),
      .idx_out        (idx_out),
      .leaf_out       (leaf_out)
   );

   int    errors = 0;
   int    checks = 0;
   list_t exp_q[$];
   list_t held = '0;
   key_t  model_r [K];
   bit    armed = 1'b0;

   function automatic list_t pack_model();
      list_t l;
      for (int i = 0; i < K; i++) l[i*KW +: KW] = model_r[i];
      return l;
   endfunction

   // ------------------------------------------------------------------
   // Monitor: compares every output cycle against the scoreboard
   // ------------------------------------------------------------------
   always @(negedge clk) begin : mon
      list_t got;
      list_t e;
      if (armed && !rst) begin
         for (int i = 0; i < K; i++)
            got[i*KW +: KW] = {data_out[i*DW +: DW], leaf_out[i*LW +: LW], idx_out[i*IW +: IW]};
         checks++;
         if (valid_out) begin
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_pulse valid_out=1 required=0 list=%h", got);
               held = got;
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin
                  errors++;
                  $display("FAIL result got=%h required=%h", got, e);
               end
`ifdef TOPK_DIST_THRESH_EN
               for (int i = 0; i < K; i++) begin
                  checks++;
                  if (elem_valid_out[i] !== (e[i*KW+KW-1 -: DW] != {DW{1'b1}})) begin
                     errors++;
                     $display("FAIL elem_valid[%0d] got=%b", i, elem_valid_out[i]);
                  end
               end
`endif
               held = e;
            end
         end else if (got !== held) begin
            errors++;
            $display("FAIL hold got=%h required=%h", got, held);
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic send(input bit f, input bit l, input int leaf,
                       input int d [N], input int ix [N]);
      key_t b [N];
      key_t pool[$];
      int   pos;
      valid_in = 1'b1;
      first_in = f;
      last_in  = l;
      leaf_in  = leaf[LW-1:0];
      for (int i = 0; i < N; i++) begin
         data_in[i*DW +: DW] = d[i][DW-1:0];
         idx_in[i*IW +: IW]  = ix[i][IW-1:0];
         b[i] = {d[i][DW-1:0], leaf[LW-1:0], ix[i][IW-1:0]};
`ifdef TOPK_DIST_THRESH_EN
         if (d[i][DW-1:0] >= thr) b[i] = SENT;
`endif
      end
      // Reference: K smallest keys of (batch, plus running list unless first)
      pool = {};
      for (int i = 0; i < N + K; i++) begin
         key_t x;
         if (i < N) x = b[i];
         else if (!f) x = model_r[i-N];
         else continue;
         pos = 0;
         while (pos < pool.size() && pool[pos] <= x) pos++;
         pool.insert(pos, x);
      end
      for (int i = 0; i < K; i++) model_r[i] = pool[i];
      if (l) exp_q.push_back(pack_model());
      step();
      valid_in = 1'b0;
      first_in = 1'b0;
      last_in  = 1'b0;
   endtask

   task automatic check_reset_state();
      checks++;
      if (valid_out !== 1'b0 || data_out !== '0 || idx_out !== '0 || leaf_out !== '0) begin
         errors++;
         $display("FAIL reset_state valid=%b data=%h idx=%h leaf=%h required all 0",
                  valid_out, data_out, idx_out, leaf_out);
      end
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      valid_in = 1'b0;
      step();
      exp_q.delete();
      for (int i = 0; i < K; i++) model_r[i] = SENT;
      held = '0;
      rst  = 1'b0;
      check_reset_state();
   endtask

   // ------------------------------------------------------------------
   // Test sequence
   // ------------------------------------------------------------------
   initial begin : stim
      int d  [N];
      int ix [N];
      int nb;
      int leaf;
      int w;
      bit f;
      bit l;

      for (int i = 0; i < K; i++) model_r[i] = SENT;
      step();
      do_reset();
      armed = 1'b1;

      // Single batch with fixed latency and constant expected values
      d  = '{70, 10, 50, 30, 80, 20, 60, 40};
      ix = '{0, 1, 2, 3, 4, 5, 6, 7};
      send(1'b1, 1'b1, 5, d, ix);
      idle(5);
      checks++;
      if (valid_out !== 1'b0) begin
         errors++;
         $display("FAIL latency_early valid_out=%b required=0", valid_out);
      end
      idle(1);
      checks++;
      if (valid_out !== 1'b1 || data_out !== {25'd40, 25'd30, 25'd20, 25'd10} ||
          idx_out !== {9'd7, 9'd3, 9'd5, 9'd1} || leaf_out !== {6'd5, 6'd5, 6'd5, 6'd5}) begin
         errors++;
         $display("FAIL single_batch valid=%b data=%h idx=%h leaf=%h", valid_out, data_out, idx_out, leaf_out);
      end
      idle(1);
      checks++;
      if (valid_out !== 1'b0) begin
         errors++;
         $display("FAIL pulse_width valid_out=%b required=0", valid_out);
      end

      // Three back-to-back batches of one query
      d = '{90, 80, 70, 60, 55, 50, 45, 40};
      send(1'b1, 1'b0, 1, d, ix);
      d = '{35, 35, 35, 35, 35, 35, 35, 35};
      send(1'b0, 1'b0, 2, d, ix);
      d = '{41, 39, 1000, 2000, 3000, 4000, 5000, 6000};
      send(1'b0, 1'b1, 3, d, ix);
      idle(8);
      checks++;
      if (data_out !== {4{25'd35}} || leaf_out !== {4{6'd2}} || idx_out !== {9'd3, 9'd2, 9'd1, 9'd0}) begin
         errors++;
         $display("FAIL three_batch data=%h idx=%h leaf=%h", data_out, idx_out, leaf_out);
      end

      // Ties on distance resolve to the smaller index
      d  = '{100, 100, 100, 100, 100, 100, 100, 100};
      ix = '{7, 6, 5, 4, 3, 2, 1, 0};
      send(1'b1, 1'b1, 0, d, ix);
      idle(8);
      checks++;
      if (idx_out !== {9'd3, 9'd2, 9'd1, 9'd0}) begin
         errors++;
         $display("FAIL ties idx=%h required=%h", idx_out, {9'd3, 9'd2, 9'd1, 9'd0});
      end

      // Two single-batch queries back to back
      d  = '{5, 6, 7, 8, 9, 10, 11, 12};
      ix = '{0, 1, 2, 3, 4, 5, 6, 7};
      send(1'b1, 1'b1, 9, d, ix);
      d  = '{300, 200, 100, 400, 250, 150, 50, 350};
      send(1'b1, 1'b1, 10, d, ix);
      idle(9);

      // Reset three cycles after the first of a two-batch query
      send(1'b1, 1'b0, 4, d, ix);
      send(1'b0, 1'b1, 4, d, ix);
      idle(1);
      do_reset();
      idle(10);

      // Non-first batch with no open query merges against the sentinel list
      d = '{17, 3, 99, 42, 8, 61, 25, 77};
      send(1'b0, 1'b1, 7, d, ix);
      // Fresh query after reset, and a new first discarding an open query
      send(1'b1, 1'b0, 8, d, ix);
      d = '{1, 2, 3, 4, 5, 6, 7, 8};
      send(1'b1, 1'b1, 12, d, ix);
      idle(9);

`ifdef TOPK_DIST_THRESH_EN
      d  = '{70, 10, 50, 30, 80, 20, 60, 40};
      thr = 25'd50;
      send(1'b1, 1'b1, 5, d, ix);
      thr = 25'd25;
      send(1'b1, 1'b1, 5, d, ix);
      thr = '1;
      idle(9);
`endif

      // Randomised queries with gaps and occasional irregular flags
      for (int q = 0; q < 60; q++) begin
         nb = $urandom_range(1, 4);
         for (int b = 0; b < nb; b++) begin
            f = (b == 0);
            l = (b == nb - 1);
            if ($urandom_range(0, 9) == 0) begin
               f = ($urandom_range(0, 1) == 1);
               l = ($urandom_range(0, 1) == 1);
            end
            leaf = $urandom_range(0, 63);
            for (int i = 0; i < N; i++) begin
               if ($urandom_range(0, 15) == 0) d[i] = 33554431;
               else d[i] = $urandom_range(0, 300);
               ix[i] = $urandom_range(0, 511);
            end
            send(f, l, leaf, d, ix);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         end
      end

      // Drain with a bounded wait
      w = 0;
      while (exp_q.size() != 0 && w < 50) begin
         step();
         w++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      idle(3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
